miriscv_lsu_ctrl: RTL and testbench

Load-store sequencer between the core's execute stage and the data-memory port.
- Consumes the decoder's memory controls: mem_req, mem_we and mem_size.
- Holds the pipeline stalled while a req/gnt/rvalid transaction runs.
- Generates byte enables and replicated write data.
- Returns sign- or zero-extended load data.
- Flags misaligned addresses and invalid sizes without touching memory.

---
 rtl/miriscv_lsu_ctrl_pkg.sv | 32 +++
 rtl/miriscv_lsu_align.sv | 59 +++++
 rtl/miriscv_lsu_ctrl.sv | 152 +++++++++++++++
 tb/tb_miriscv_lsu_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_lsu_ctrl_pkg.sv
//==============================================================================
// Module  : miriscv_lsu_ctrl_pkg
// Brief   : Load/store size codes, LSU FSM state encodings and counter sizing.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package miriscv_lsu_ctrl_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

    // Timeout counter width: wide enough for the limit, clamped to 8..16 bits.
    function automatic int unsigned lsu_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/miriscv_lsu_align.sv
//==============================================================================
// Module  : miriscv_lsu_align
// Brief   : Byte-enable / store-replication / load-extension logic and the
//           size/alignment legality check for one memory access.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module miriscv_lsu_align
    import miriscv_lsu_ctrl_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_legal
);

    logic [15:0] w_lane;

    // Only the low halfword of the shifted word is ever extracted.
    assign w_lane = 16'(i_rdata >> {i_offset, 3'b000});

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        o_legal = 1'b0;
        case (i_size)
            LDST_B, LDST_BU: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_size == LDST_B) ? {{24{w_lane[7]}}, w_lane[7:0]}
                                             : {24'd0, w_lane[7:0]};
                o_legal = 1'b1;
            end
            LDST_H, LDST_HU: begin
                o_be    = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_size == LDST_H) ? {{16{w_lane[15]}}, w_lane}
                                             : {16'd0, w_lane};
                o_legal = ~i_offset[0];
            end
            LDST_W: begin
                o_be    = 4'b1111;
                o_legal = (i_offset == 2'b00);
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/miriscv_lsu_ctrl.sv
//==============================================================================
// Module  : miriscv_lsu_ctrl
// Brief   : Load-store sequencer: stalls the pipeline over a req/gnt/rvalid
//           memory transaction. Optional abort timer: MIRISCV_LSU_TIMEOUT_EN.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module miriscv_lsu_ctrl
    import miriscv_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [2:0]  w_size;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_ext;
    logic        w_legal;
    logic        w_idle;
    logic        w_accept;
    logic        w_reject;
    logic        w_abort;

    // Live inputs are decoded in IDLE; the latched access drives load extraction.
    assign w_idle = (r_state == LSU_IDLE);
    assign w_size = w_idle ? lsu_size_i      : r_size;
    assign w_off  = w_idle ? lsu_addr_i[1:0] : r_off;

    miriscv_lsu_align u_align (
        .i_size   (w_size),
        .i_offset (w_off),
        .i_wdata  (lsu_data_i),
        .i_rdata  (data_rdata_i),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata_ext),
        .o_legal  (w_legal)
    );

    assign w_accept = w_idle & lsu_req_i & w_legal;
    assign w_reject = w_idle & lsu_req_i & ~w_legal;

`ifdef MIRISCV_LSU_TIMEOUT_EN
    localparam int unsigned c_cnt_w = lsu_cnt_width(TIMEOUT_CYCLES);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_busy;
    logic               w_timeout;

    assign w_busy = (r_state == LSU_REQ) | (r_state == LSU_RESP);

    // Held at zero outside REQ/RESP so every transaction starts from zero.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = w_busy & (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
`endif

    // Normal progress wins over a timeout landing on the same cycle.
    assign w_abort = w_timeout & (((r_state == LSU_REQ)  & ~data_gnt_i) |
                                  ((r_state == LSU_RESP) & ~data_rvalid_i));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: if (w_accept)                      w_state_nxt = LSU_REQ;
            LSU_REQ:  if (data_gnt_i)                    w_state_nxt = LSU_RESP;
                      else if (w_abort)                  w_state_nxt = LSU_DONE;
            LSU_RESP: if (data_rvalid_i || w_abort)      w_state_nxt = LSU_DONE;
            default:                                     w_state_nxt = LSU_IDLE;
        endcase
    end

    always_comb begin
        data_req_o      = (r_state == LSU_REQ);
        lsu_stall_req_o = lsu_req_i & w_legal & (r_state != LSU_DONE);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= 32'd0;
            data_wdata_o <= 32'd0;
            r_size       <= 3'd0;
            r_off        <= 2'd0;
            lsu_data_o   <= 32'd0;
            lsu_err_o    <= 1'b0;
        end else begin
            lsu_err_o <= w_reject | w_abort;
            if (w_accept) begin
                data_we_o    <= lsu_we_i;
                data_be_o    <= w_be;
                data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                data_wdata_o <= w_wdata;
                r_size       <= lsu_size_i;
                r_off        <= lsu_addr_i[1:0];
            end
            if (w_abort) begin
                lsu_data_o <= 32'd0;
            end else if ((r_state == LSU_RESP) && data_rvalid_i && !data_we_o) begin
                lsu_data_o <= w_rdata_ext;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_miriscv_lsu_ctrl.sv
//==============================================================================
// Module  : tb_miriscv_lsu_ctrl
// Brief   : Scoreboard bench for miriscv_lsu_ctrl (directed load/store vectors).
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_miriscv_lsu_ctrl;

    localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'd0;
    logic [31:0] lsu_addr_i = 32'd0;
    logic [31:0] lsu_data_i = 32'd0;
    logic        lsu_stall_req_o;
    logic [31:0] lsu_data_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    always #5 clk_i = ~clk_i;

    miriscv_lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_data_o      (lsu_data_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [68:0] exp_req_q[$];   // {we, be, addr, wdata}
    logic [31:0] exp_rsp_q[$];
    int          exp_err_q[$];
    int          stall_total = 0;
    int          req_total = 0;
    bit          rsp_pending = 1'b0;
    bit          rv_stray = 1'b0;

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request, a
    // completed response or an error pulse.
    always @(negedge clk_i) begin
        if (lsu_stall_req_o) stall_total++;
        if (data_req_o)      req_total++;
        if (rsp_pending) begin
            if (exp_rsp_q.size() == 0) check("rsp_unexpected", 69'd1, 69'd0);
            else                       check("lsu_data", {37'd0, lsu_data_o}, {37'd0, exp_rsp_q.pop_front()});
            check("stall_in_done", {68'd0, lsu_stall_req_o}, 69'd0);
        end
        rsp_pending = data_rvalid_i && !rv_stray && arstn_i;
        if (data_req_o && data_gnt_i) begin
            if (exp_req_q.size() == 0) check("req_unexpected", 69'd1, 69'd0);
            else check("mem_req", {data_we_o, data_be_o, data_addr_o, data_wdata_o}, exp_req_q.pop_front());
        end
        if (lsu_err_o) begin
            check("err_expected", {68'd0, exp_err_q.size() != 0}, 69'd1);
            if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
            check("err_no_req", {68'd0, data_req_o}, 69'd0);
        end
    end

    task automatic txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int gd,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_rsp);
        int s0, r0;
        s0 = stall_total;
        r0 = req_total;
        exp_req_q.push_back({we, exp_be, addr[31:2], 2'b00, exp_wd});
        exp_rsp_q.push_back(exp_rsp);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = addr; lsu_data_i = wd;
        @(posedge clk_i); #1;
        repeat (gd) begin @(posedge clk_i); #1; end
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = rd;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        check("stall_cycles", 69'(stall_total - s0), 69'(gd + 3));
        check("req_cycles", 69'(req_total - r0), 69'(gd + 1));
    endtask

    task automatic illegal(input logic [2:0] sz, input logic [31:0] addr);
        int s0, r0;
        s0 = stall_total;
        r0 = req_total;
        exp_err_q.push_back(1);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = sz; lsu_addr_i = addr;
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        @(posedge clk_i); #1;
        check("illegal_stall", 69'(stall_total - s0), 69'd0);
        check("illegal_req", 69'(req_total - r0), 69'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", {data_req_o, data_we_o, data_be_o, lsu_err_o, lsu_stall_req_o}, 69'd0);
        check("reset_addr_wdata", {5'd0, data_addr_o, data_wdata_o}, 69'd0);
        check("reset_lsu_data", {37'd0, lsu_data_o}, 69'd0);
        arstn_i = 1'b1;

        txn(1'b0, SZ_W,  32'h104, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
        txn(1'b0, SZ_B,  32'h103, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
        txn(1'b0, SZ_BU, 32'h103, 32'h0,        32'h80FF0000, 1, 4'b1000, 32'h0,        32'h00000080);
        txn(1'b1, SZ_H,  32'h022, 32'h0000ABCD, 32'h12345678, 3, 4'b1100, 32'hABCDABCD, 32'h00000080);
        txn(1'b1, SZ_B,  32'h101, 32'h1234565A, 32'h0,        1, 4'b0010, 32'h5A5A5A5A, 32'h00000080);
        txn(1'b0, SZ_H,  32'h002, 32'h0,        32'h80010000, 2, 4'b1100, 32'h0,        32'hFFFF8001);

        illegal(SZ_W, 32'h101);
        illegal(3'd3, 32'h100);
        illegal(3'd6, 32'h100);
        illegal(SZ_H, 32'h103);
        illegal(SZ_W, 32'h102);

        // Reset while the load sits in RESP: outputs clear at once, late rvalid ignored.
        exp_req_q.push_back({1'b0, 4'b1111, 32'h200, 32'h0});
        @(posedge clk_i); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = SZ_W; lsu_addr_i = 32'h200; lsu_data_i = 32'h0;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        arstn_i = 1'b0; lsu_req_i = 1'b0;
        #1;
        check("arst_ctrl", {data_req_o, data_we_o, data_be_o, lsu_err_o, lsu_stall_req_o}, 69'd0);
        check("arst_addr_wdata", {5'd0, data_addr_o, data_wdata_o}, 69'd0);
        check("arst_lsu_data", {37'd0, lsu_data_o}, 69'd0);
        @(posedge clk_i); #1;
        arstn_i = 1'b1;
        r0 = req_total;
        rv_stray = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        @(posedge clk_i); #1;
        rv_stray = 1'b0;
        check("stray_rvalid_data", {37'd0, lsu_data_o}, 69'd0);
        check("stray_rvalid_req", 69'(req_total - r0), 69'd0);

        txn(1'b0, SZ_HU, 32'h002, 32'h0, 32'h80010000, 0, 4'b1100, 32'h0, 32'h00008001);

`ifdef MIRISCV_LSU_TIMEOUT_EN
        begin
            int k;
            k = 0;
            exp_err_q.push_back(1);
            @(posedge clk_i); #1;
            lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = SZ_W; lsu_addr_i = 32'h300;
            while (!lsu_err_o && k < 40) begin
                @(posedge clk_i); #1;
                k++;
            end
            check("timeout_latency", 69'(k), 69'd9);
            check("timeout_data", {37'd0, lsu_data_o}, 69'd0);
            @(posedge clk_i); #1;
            lsu_req_i = 1'b0;
        end
`endif

        repeat (3) @(posedge clk_i);
        #1;
        check("req_queue_drained", 69'(exp_req_q.size()), 69'd0);
        check("rsp_queue_drained", 69'(exp_rsp_q.size()), 69'd0);
        check("err_queue_drained", 69'(exp_err_q.size()), 69'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
